load_store_unit: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the datapath's ALU and store-data mux and upstream of the write-back mux. It takes the effective address and store data for the current load/store instruction and drives a word-wide handshaked memory bus. It handles byte, halfword and word sizes, sign/zero extension, and misaligned accesses, which it splits into two bus transfers. While busy it stalls the core by deasserting the PC write condition.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/load_store_unit_align.sv | 49 ++++
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types: funct3 codes, FSM states,
// access-size mask and funct3 legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } lsu_state_e;

  function automatic logic [3:0] size_mask(
    input logic [2:0] f3
  );
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic f3_legal(
    input logic       st,
    input logic [2:0] f3
  );
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~st;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for both bus phases: byte enables, store data
// shifting, and load merge with sign/zero extension.
module load_store_unit_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rlo_i,
  input  logic [31:0] rhi_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wd_lo_o,
  output logic [31:0] wd_hi_o,
  output logic        split_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [31:0] rd;
  logic [5:0]  sh;

  assign sh = {1'b0, off_i, 3'b000};

  always_comb begin
    be8  = {4'b0000, size_mask(funct3_i)} << off_i;
    wd64 = {32'b0, wdata_i} << sh;
    rd   = 32'({rhi_i, rlo_i} >> sh);
  end

  assign be_lo_o = be8[3:0];
  assign be_hi_o = be8[7:4];
  assign wd_lo_o = wd64[31:0];
  assign wd_hi_o = wd64[63:32];
  assign split_o = |be8[7:4];

  always_comb begin
    ldata_o = rd;
    case (funct3_i)
      F3_B:  ldata_o = {{24{rd[7]}}, rd[7:0]};
      F3_H:  ldata_o = {{16{rd[15]}}, rd[15:0]};
      F3_BU: ldata_o = {24'b0, rd[7:0]};
      F3_HU: ldata_o = {16'b0, rd[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: request latch, two-phase bus FSM
// for misaligned accesses, per-transfer timeout, registered result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  lsu_state_e  state_q, state_d;
  logic        st_q, st_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd0_q, rd0_d;
  logic        err_q, err_d;
  logic [31:0] ld_q, ld_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]  be_lo, be_hi;
  logic [31:0] wd_lo, wd_hi;
  logic [31:0] merged;
  logic        split;
  logic [31:0] wa0, wa1;
  logic        tmo;

  // Unsplit loads merge straight from the live bus word.
  load_store_unit_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wd_q),
    .rlo_i    (state_q == S_ACC0 ? mem_rdata : rd0_q),
    .rhi_i    (mem_rdata),
    .be_lo_o  (be_lo),
    .be_hi_o  (be_hi),
    .wd_lo_o  (wd_lo),
    .wd_hi_o  (wd_hi),
    .split_o  (split),
    .ldata_o  (merged)
  );

  assign wa0 = {addr_q[31:2], 2'b00};
  assign wa1 = wa0 + 32'd4;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign load_data = ld_q;

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    rd0_d     = rd0_q;
    err_d     = err_q;
    ld_d      = ld_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          st_d   = is_store;
          f3_d   = funct3;
          addr_d = addr;
          wd_d   = wdata;
          cnt_d  = '0;
          if (f3_legal(is_store, funct3)) begin
            err_d   = 1'b0;
            state_d = S_ACC0;
          end else begin
            err_d   = 1'b1;
            ld_d    = '0;
            state_d = S_RESP;
          end
        end
      end
      S_ACC0: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = st_q;
        mem_addr  = wa0;
        mem_be    = be_lo;
        mem_wdata = wd_lo;
        if (mem_ready) begin
          rd0_d = mem_rdata;
          if (split) begin
            cnt_d   = '0;
            state_d = S_ACC1;
          end else begin
            ld_d    = st_q ? '0 : merged;
            state_d = S_RESP;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          ld_d    = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACC1: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = st_q;
        mem_addr  = wa1;
        mem_be    = be_hi;
        mem_wdata = wd_hi;
        if (mem_ready) begin
          ld_d    = st_q ? '0 : merged;
          state_d = S_RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          ld_d    = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd0_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd0_q   <= rd0_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, a
// wait-state bus responder and a decoupled output monitor.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] ld;
    logic        chk_ld;
    int          issue;
    int          lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int smp = 0;
  int req_cycles = 0;
  int done_cnt = 0;
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];

  int          wait_n[2];
  logic [31:0] rd_w[2];
  int          xi = 0;
  int          wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Bus responder: wait_n[k] idle cycles before accepting transfer k.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        xi++;
        wcnt = 0;
      end
      mem_ready = 1'b0;
      if (mem_req) begin
        if (wcnt >= wait_n[xi % 2]) begin
          mem_ready = 1'b1;
          mem_rdata = rd_w[xi % 2];
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: compares every bus cycle and every completion.
  initial begin
    bus_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      #1;
      smp++;
      if (!reset) continue;
      if (mem_req) begin
        req_cycles++;
        chk("stall_busy", stall, 1'b1);
        if (exp_bus.size() == 0) begin
          chk("unexpected_mem_req", mem_req, 1'b0);
        end else begin
          b = exp_bus[0];
          chk("mem_addr", mem_addr, b.a);
          chk("mem_be", mem_be, b.be);
          chk("mem_we", mem_we, b.we);
          if (b.we)
            chk("mem_wdata", mem_wdata & lane_mask(b.be),
                b.wd & lane_mask(b.be));
          if (mem_ready) void'(exp_bus.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_rsp.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          r = exp_rsp.pop_front();
          chk("err", err, r.err);
          chk("done_latency", smp - r.issue, r.lat);
          chk("stall_resp", stall, 1'b0);
          chk("mem_req_resp", mem_req, 1'b0);
          if (r.chk_ld) chk("load_data", load_data, r.ld);
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [3:0] be,
                      input logic we, input logic [31:0] wd);
    bus_t b;
    b = '{a: a, be: be, we: we, wd: wd};
    exp_bus.push_back(b);
  endtask

  task automatic run_op(
    input logic st, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] w0, input logic [31:0] w1,
    input int wt0, input int wt1,
    input logic e_err, input logic e_chk,
    input logic [31:0] e_ld, input int lat
  );
    rsp_t r;
    logic got;
    rd_w[0]   = w0;
    rd_w[1]   = w1;
    wait_n[0] = wt0;
    wait_n[1] = wt1;
    xi   = 0;
    wcnt = 0;
    r = '{err: e_err, ld: e_ld, chk_ld: e_chk,
          issue: smp + 1, lat: lat};
    exp_rsp.push_back(r);
    req_cycles = 0;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk);
      #2;
      got = done;
    end
    chk("done_seen", got, 1'b1);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int dn0;
    reset     = 1'b0;
    req_valid = 1'b0;
    is_store  = 1'b0;
    funct3    = '0;
    addr      = '0;
    wdata     = '0;
    wait_n[0] = 0;
    wait_n[1] = 0;
    rd_w[0]   = '0;
    rd_w[1]   = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_stall_lo", stall, 1'b0);
    req_valid = 1'b1;
    #1;
    chk("rst_stall_hi", stall, 1'b1);
    req_valid = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #2;

    xfer(32'h100, 4'hF, 1'b0, 32'h0);
    run_op(0, F3_W, 32'h100, 0, 32'h8001_0203, 0, 0, 0,
           0, 1, 32'h8001_0203, 2);
    chk("lw_req_cycles", req_cycles, 1);
    @(posedge clk);
    #2;
    chk("ld_hold", load_data, 32'h8001_0203);

    xfer(32'h100, 4'h8, 1'b0, 32'h0);
    run_op(0, F3_B, 32'h103, 0, 32'h8012_3456, 0, 0, 0,
           0, 1, 32'hFFFF_FF80, 2);
    xfer(32'h100, 4'h8, 1'b0, 32'h0);
    run_op(0, F3_BU, 32'h103, 0, 32'h8012_3456, 0, 0, 0,
           0, 1, 32'h0000_0080, 2);

    xfer(32'h100, 4'hC, 1'b1, 32'hCCDD_0000);
    xfer(32'h104, 4'h3, 1'b1, 32'h0000_AABB);
    run_op(1, F3_W, 32'h102, 32'hAABB_CCDD, 0, 0, 0, 0,
           0, 0, 32'h0, 3);
    chk("sw_req_cycles", req_cycles, 2);

    xfer(32'hFFFF_FFFC, 4'h8, 1'b0, 32'h0);
    xfer(32'h0000_0000, 4'h1, 1'b0, 32'h0);
    run_op(0, F3_H, 32'hFFFF_FFFF, 0, 32'h1122_3344,
           32'h5566_7722, 0, 0, 0, 1, 32'h0000_2211, 3);

    xfer(32'h204, 4'hC, 1'b0, 32'h0);
    run_op(0, F3_H, 32'h206, 0, 32'h9ABC_0000, 0, 2, 0,
           0, 1, 32'hFFFF_9ABC, 4);
    xfer(32'h204, 4'hC, 1'b0, 32'h0);
    run_op(0, F3_HU, 32'h206, 0, 32'h9ABC_0000, 0, 0, 0,
           0, 1, 32'h0000_9ABC, 2);

    xfer(32'h300, 4'h2, 1'b1, 32'h0000_EE00);
    run_op(1, F3_B, 32'h301, 32'h0000_00EE, 0, 0, 0, 0,
           0, 0, 32'h0, 2);

    xfer(32'h300, 4'h8, 1'b1, 32'h3400_0000);
    xfer(32'h304, 4'h1, 1'b1, 32'h0000_0012);
    run_op(1, F3_H, 32'h303, 32'h0000_1234, 0, 0, 1, 1,
           0, 0, 32'h0, 5);

    xfer(32'h100, 4'hE, 1'b0, 32'h0);
    xfer(32'h104, 4'h1, 1'b0, 32'h0);
    run_op(0, F3_W, 32'h101, 0, 32'h4433_2211,
           32'h8877_6655, 0, 0, 0, 1, 32'h5544_3322, 3);

    xfer(32'h400, 4'hF, 1'b0, 32'h0);
    run_op(0, F3_W, 32'h400, 0, 32'hDEAD_BEEF, 0, 1000, 0,
           1, 1, 32'h0, 17);
    chk("tmo_req_cycles", req_cycles, 16);
    chk("tmo_bus_left", exp_bus.size(), 1);
    exp_bus.delete();

    run_op(0, 3'b011, 32'h100, 0, 0, 0, 0, 0,
           1, 0, 32'h0, 1);
    chk("ill_ld_req_cycles", req_cycles, 0);
    run_op(1, F3_BU, 32'h100, 0, 0, 0, 0, 0,
           1, 0, 32'h0, 1);
    chk("ill_st_req_cycles", req_cycles, 0);

    // Reset pulse while the second transfer is still waiting.
    xfer(32'h1FC, 4'hC, 1'b0, 32'h0);
    xfer(32'h200, 4'h3, 1'b0, 32'h0);
    rd_w[0]   = 32'h1234_5678;
    rd_w[1]   = 32'h9ABC_DEF0;
    wait_n[0] = 0;
    wait_n[1] = 1000;
    xi   = 0;
    wcnt = 0;
    dn0  = done_cnt;
    is_store  = 1'b0;
    funct3    = F3_W;
    addr      = 32'h1FE;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !(mem_req && exp_bus.size() == 1);
         i++) begin
      @(posedge clk);
      #2;
    end
    chk("acc1_addr", mem_addr, 32'h200);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_mem_be", mem_be, 4'h0);
    repeat (2) @(posedge clk);
    #2;
    req_valid = 1'b0;
    exp_bus.delete();
    xi   = 0;
    wcnt = 0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_no_done", done_cnt, dn0);

    xfer(32'h100, 4'hF, 1'b0, 32'h0);
    run_op(0, F3_W, 32'h100, 0, 32'h0BAD_F00D, 0, 0, 0,
           0, 1, 32'h0BAD_F00D, 2);
    chk("post_rst_req_cycles", req_cycles, 1);
    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

endmodule
